cbx_param_cfg: RTL
==================

Name: cbx_param_cfg

Overview:
Parametrised X-channel connection block with a double-buffered configuration chain. Left/right channel tracks pass straight through. NUM_IPINS tree muxes select grid input pins from a parametrised track pattern. Configuration bits shift in through a ccff chain and reach the muxes only on an explicit commit, and only when a bit count confirms the chain was fully loaded; so reprogramming never glitches live routing. Instances sit along the channel edges of the fabric, chained head-to-tail with the other cfg blocks.

Parameters:
CHAN_WIDTH, 30, tracks per direction
NUM_IPINS, 4, number of grid input pins driven
MUX_SIZE, 12, inputs per ipin mux; must be even and ≤ CHAN_WIDTH*2
SEL_BITS, $clog2(MUX_SIZE), select bits per mux
TRACK_STRIDE, 3, track spacing between successive mux input pairs
CHAIN_LEN, NUM_IPINS*SEL_BITS, config bits in this block (derived, not overridable)

Ports:
prog_clk  in  1  configuration/fabric clock
pReset  in  1  synchronous active-high reset
ccff_head  in  1  config chain serial input
cfg_shift_en  in  1  shift chain one bit this cycle
cfg_commit  in  1  single-cycle request to transfer chain into active config
chanx_left_in  in  CHAN_WIDTH  tracks entering from left
chanx_right_in  in  CHAN_WIDTH  tracks entering from right
chanx_left_out  out  CHAN_WIDTH  = chanx_right_in, combinational
chanx_right_out  out  CHAN_WIDTH  = chanx_left_in, combinational
ipin_out  out  NUM_IPINS  mux outputs to grid pins
ccff_tail  out  1  config chain serial output
cfg_valid  out  1  active config holds a successful commit
cfg_err  out  1  sticky: commit attempted with wrong bit count
cfg_sel_bad  out  NUM_IPINS  active select ≥ MUX_SIZE, one bit per pin

Behaviour:
- Reset requirement: one clock and a synchronous active-high reset (prog_clk, pReset), as already decided.
- Registers:
  - shift register sr[0..CHAIN_LEN-1]
  - shadow register act[0..CHAIN_LEN-1]
  - bit counter cnt, width $clog2(CHAIN_LEN+1), saturating at CHAIN_LEN
  - flags cfg_valid and cfg_err
- Reset (pReset=1 at prog_clk edge): sr=0, act=0, cnt=0, cfg_valid=0, cfg_err=0. Reset overrides shift and commit in the same cycle.
- Shift (cfg_shift_en=1): sr[0]<=ccff_head, sr[i]<=sr[i-1]; ccff_tail=sr[CHAIN_LEN-1] (registered, 1 bit per shift of latency through the block); cnt<=min(cnt+1, CHAIN_LEN).
- With cfg_shift_en=0, sr and cnt hold; ccff_tail holds.
- Commit (cfg_commit=1), evaluated on the pre-edge values of sr and cnt:
  - If cnt==CHAIN_LEN: act<=sr, cfg_valid<=1.
  - Otherwise: act unchanged, cfg_valid unchanged, cfg_err<=1.
  - In both cases cnt<=0, or 1 if cfg_shift_en=1 in the same cycle.
- Simultaneous shift+commit: commit captures sr before this cycle's shift; the shift still happens.
- cfg_err is sticky and clears only on pReset. Overshifting (>CHAIN_LEN bits) saturates cnt and is accepted; the last CHAIN_LEN bits win.
- Select field for pin k: sel_k = act[k*SEL_BITS +: SEL_BITS], LSB at lower index. Bitstream order is last pin's MSB first and pin 0's LSB last.
- Mux input pattern: for pair p in 0..MUX_SIZE/2-1, t=(k + TRACK_STRIDE*p) mod CHAN_WIDTH; in[2p]=chanx_left_in[t], in[2p+1]=chanx_right_in[t].
- ipin_out[k] = cfg_valid && sel_k<MUX_SIZE ? in_k[sel_k] : 0. Combinational from act and the channel inputs; zero latency.
- cfg_sel_bad[k] = cfg_valid && sel_k≥MUX_SIZE.
- Output reset values: ipin_out=0, cfg_sel_bad=0, ccff_tail=0, cfg_valid=0, cfg_err=0. Pass-through outputs follow the inputs even during reset.
- Reset mid-shift discards the partial load. Reset after a commit clears the active config, and ipin_out returns to 0.

Decomposition:
- Shared package cbx_cfg_pkg:
  - function track_of(k,p,stride,width)
  - function clog2 helper
  - localparam defaults for CHAN_WIDTH/MUX_SIZE
- Natural sub-module cfg_chain_shadow, parametrised by CHAIN_LEN. It holds sr, act, cnt and the flags, and outputs act plus status.
- The top level generates the NUM_IPINS muxes from the pattern function and the pass-through assigns.

Test Plan:
- Reset then idle with random channel inputs -> ipin_out=0, cfg_valid=0, cfg_err=0, ccff_tail=0; chanx_right_out==chanx_left_in every cycle.
- Shift 16 bits (default params) 0×12 then 0,1,0,1, then commit -> cfg_valid=1; sel_0=5, so ipin_out[0]==chanx_right_in[6]; ipin_out[1..3] follow chanx_left_in[1],[2],[3] (sel=0).
- Shift only 15 bits, then commit -> cfg_err=1, cfg_valid stays 0, ipin_out stays 0. Then 16 more bits plus commit -> cfg_valid=1 and cfg_err still 1.
- After a valid config, shift a new 16-bit pattern without committing -> ipin_out unchanged throughout. Commit -> new selects take effect the cycle after the commit edge.
- Load sel_2=4'b1101 (13≥12) and commit -> cfg_sel_bad=4'b0100, ipin_out[2]=0.
- Shift+commit in the same cycle with cnt==16 -> act gets the pre-shift sr, cnt=1. Then 16 bits of 1s -> ccff_tail emits the previous chain contents in order, 16 shifts delayed.

Source files
------------

// File: rtl/cbx_cfg_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised connection block.
// Used to size the config chain and to wire each ipin mux to its channel tracks.
package cbx_cfg_pkg;

    localparam int DEF_CHAN_WIDTH = 30;
    localparam int DEF_MUX_SIZE   = 12;

    // Never returns 0 so that derived vector widths stay legal for tiny values.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    // Channel track feeding mux input pair p of ipin k.
    function automatic int track_of(input int k, input int p, input int stride, input int width);
        return (k + stride * p) % width;
    endfunction

endpackage

// File: rtl/cfg_chain_shadow.sv
// Serial config chain with a shadow (active) copy that is updated only by a commit
// made after exactly CHAIN_LEN or more shifted bits.
module cfg_chain_shadow
    import cbx_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_shift_en,
    input  logic                 i_commit,
    input  logic                 i_head,
    output logic [CHAIN_LEN-1:0] o_act,
    output logic                 o_tail,
    output logic                 o_valid,
    output logic                 o_err
);

    localparam int CNT_W = clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] r_sr;
    logic [CHAIN_LEN-1:0] r_act;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_valid;
    logic                 r_err;

    logic [CHAIN_LEN-1:0] w_sr_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_full;

    assign w_full = (r_cnt == CNT_W'(CHAIN_LEN));

    always_comb begin
        w_sr_next = r_sr;
        if (i_shift_en) begin
            w_sr_next[0] = i_head;
            for (int i = 1; i < CHAIN_LEN; i++) begin
                w_sr_next[i] = r_sr[i-1];
            end
        end
    end

    // A commit restarts the count; a shift in the same cycle counts as the first new bit.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_commit) begin
            w_cnt_next = i_shift_en ? CNT_W'(1) : '0;
        end else if (i_shift_en && !w_full) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr    <= '0;
            r_act   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sr  <= w_sr_next;
            r_cnt <= w_cnt_next;
            if (i_commit) begin
                if (w_full) begin
                    r_act   <= r_sr;
                    r_valid <= 1'b1;
                end else begin
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign o_act   = r_act;
    assign o_tail  = r_sr[CHAIN_LEN-1];
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule

// File: rtl/cbx_param_cfg.sv
// X-channel connection block: straight-through tracks plus NUM_IPINS tree muxes
// whose selects come from a double-buffered ccff configuration chain.
module cbx_param_cfg
    import cbx_cfg_pkg::*;
#(
    parameter int CHAN_WIDTH   = DEF_CHAN_WIDTH,
    parameter int NUM_IPINS    = 4,
    parameter int MUX_SIZE     = DEF_MUX_SIZE,
    parameter int SEL_BITS     = clog2(MUX_SIZE),
    parameter int TRACK_STRIDE = 3
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  ccff_head,
    input  logic                  cfg_shift_en,
    input  logic                  cfg_commit,
    input  logic [CHAN_WIDTH-1:0] chanx_left_in,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    output logic [CHAN_WIDTH-1:0] chanx_left_out,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [NUM_IPINS-1:0]  ipin_out,
    output logic                  ccff_tail,
    output logic                  cfg_valid,
    output logic                  cfg_err,
    output logic [NUM_IPINS-1:0]  cfg_sel_bad
);

    localparam int CHAIN_LEN = NUM_IPINS * SEL_BITS;
    localparam int IN_SPAN   = 1 << SEL_BITS;

    logic [CHAIN_LEN-1:0] w_act;
    logic                 w_valid;

    cfg_chain_shadow #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_chain (
        .i_clk      (prog_clk),
        .i_rst      (pReset),
        .i_shift_en (cfg_shift_en),
        .i_commit   (cfg_commit),
        .i_head     (ccff_head),
        .o_act      (w_act),
        .o_tail     (ccff_tail),
        .o_valid    (w_valid),
        .o_err      (cfg_err)
    );

    assign cfg_valid       = w_valid;
    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    for (genvar k = 0; k < NUM_IPINS; k++) begin : g_pin
        logic [IN_SPAN-1:0]  w_in;
        logic [SEL_BITS-1:0] w_sel;
        logic                w_sel_ok;

        assign w_sel    = w_act[k*SEL_BITS +: SEL_BITS];
        assign w_sel_ok = (int'(w_sel) < MUX_SIZE);

        // Even inputs take the left track, odd inputs the right track of the same index.
        for (genvar p = 0; p < MUX_SIZE / 2; p++) begin : g_pair
            localparam int TRK = track_of(k, p, TRACK_STRIDE, CHAN_WIDTH);
            assign w_in[2*p]   = chanx_left_in[TRK];
            assign w_in[2*p+1] = chanx_right_in[TRK];
        end

        if (IN_SPAN > MUX_SIZE) begin : g_pad
            assign w_in[IN_SPAN-1:MUX_SIZE] = '0;
        end

        assign ipin_out[k]    = w_valid && w_sel_ok && w_in[w_sel];
        assign cfg_sel_bad[k] = w_valid && !w_sel_ok;
    end

endmodule
